maxpool_collect_buf: RTL

MAXPOOL_COLLECT_BUF -- requirements
Module: maxpool_collect_buf

---
 rtl/maxpool_collect_buf.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/maxpool_collect_buf.sv
// -----------------------------------------------------------------------------
// maxpool_collect_buf
//
// Purpose:
//   Collects pooled values, written one word at a time by address, into a
//   frame buffer of N = NUM_CH*OUT_HW words. A frame is closed by a write
//   carrying in_last. The closed frame is then presented on out_data until the
//   consumer accepts it with out_ready.
//   in_value lags its in_valid/in_addr/in_last qualifiers by DLY cycles. The
//   qualifiers are therefore delayed internally so that they line up with the
//   data they describe.
//
// Configuration:
//   MAXPOOL_PINGPONG_EN
//     Defined:   two banks. One bank can fill while the other waits for the
//                consumer.
//     Undefined: one bank is both the write bank and the read bank. Writes
//                that arrive while it is FULL are dropped. Writing resumes in
//                the cycle after the consumer accepts the frame.
//
// Parameters:
//   MAX_BW  width of one pooled value
//   NUM_CH  channels per frame
//   OUT_HW  pooled positions per channel
//   DLY     cycles by which in_value lags the qualifiers (0..8)
//
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   qualifies in_addr/in_last this cycle
//   in_addr    word slot 0..N-1 (larger values are flagged on err_addr)
//   in_last    final write of a frame
//   in_value   pooled value, DLY cycles after its in_valid
//   out_valid  a complete frame is on out_data
//   out_ready  consumer accepts the frame when high together with out_valid
//   out_data   packed frame; slot k at [k*MAX_BW +: MAX_BW]; zero when idle
//   err_addr   sticky: an out-of-range address was seen
//   err_ovf    sticky: a write was dropped because no bank was free
//   frame_cnt  frames accepted by the consumer, modulo 2^16
// -----------------------------------------------------------------------------
module maxpool_collect_buf #(
   parameter  int MAX_BW = 8,
   parameter  int NUM_CH = 4,
   parameter  int OUT_HW = 4,
   parameter  int DLY    = 5,
   localparam int N      = NUM_CH * OUT_HW,
   localparam int AW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   input  logic [AW-1:0]       in_addr,
   input  logic                in_last,
   input  logic [MAX_BW-1:0]   in_value,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N*MAX_BW-1:0] out_data,
   output logic                err_addr,
   output logic                err_ovf,
   output logic [15:0]         frame_cnt
);

`ifdef MAXPOOL_PINGPONG_EN
   localparam bit PINGPONG = 1'b1;
`else
   localparam bit PINGPONG = 1'b0;
`endif

   localparam logic [AW:0] NLIM = (AW+1)'(N);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2
   } bankState_t;

   logic          wValid;
   logic [AW-1:0] wAddr;
   logic          wLast;

   // ---- qualifier delay pipeline: realigns valid/addr/last with in_value ----
   generate
      if (DLY == 0) begin : gNoDly
         assign wValid = in_valid;
         assign wAddr  = in_addr;
         assign wLast  = in_last;
      end else begin : gDly
         logic          validPipe [DLY];
         logic [AW-1:0] addrPipe  [DLY];
         logic          lastPipe  [DLY];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < DLY; i++) begin
                  validPipe[i] <= 1'b0;
                  addrPipe[i]  <= '0;
                  lastPipe[i]  <= 1'b0;
               end
            end else begin
               validPipe[0] <= in_valid;
               addrPipe[0]  <= in_addr;
               lastPipe[0]  <= in_last;
               for (int i = 1; i < DLY; i++) begin
                  validPipe[i] <= validPipe[i-1];
                  addrPipe[i]  <= addrPipe[i-1];
                  lastPipe[i]  <= lastPipe[i-1];
               end
            end
         end

         assign wValid = validPipe[DLY-1];
         assign wAddr  = addrPipe[DLY-1];
         assign wLast  = lastPipe[DLY-1];
      end
   endgenerate

   // ---- bank control: write/release decisions and next bank states ----
   // Two state slots are always declared. In single-bank builds both pointers
   // stay at 0, so slot 1 never leaves EMPTY and its storage is never written.
   bankState_t        bankState [2];
   bankState_t        bankNext  [2];
   logic              wrPtr, rdPtr;
   logic              wrPtrNext, rdPtrNext;
   logic [MAX_BW-1:0] mem [2][N];

   logic inRange;
   logic relBank;
   logic acceptWr;
   logic dropWr;

   assign out_valid = (bankState[rdPtr] == FULL);

   always_comb begin
      inRange   = ({1'b0, wAddr} < NLIM);
      relBank   = out_valid && out_ready;
      // A FULL write bank may still take the write if it is being released
      // in this same cycle. That can only happen with two banks. A single
      // bank holds writes off until the cycle after the handshake.
      acceptWr  = wValid && ((bankState[wrPtr] != FULL) ||
                             (PINGPONG && relBank && (rdPtr == wrPtr)));
      dropWr    = wValid && !acceptWr;
      bankNext  = bankState;
      wrPtrNext = wrPtr;
      rdPtrNext = rdPtr;

      if (relBank) begin
         bankNext[rdPtr] = EMPTY;
         rdPtrNext       = PINGPONG ? ~rdPtr : 1'b0;
      end

      // The write is applied after the release, so a bank that is reused in
      // the same cycle ends up in FILL or FULL rather than EMPTY.
      if (acceptWr) begin
         if (wLast) begin
            // The frame closes even if this last write was out of range.
            bankNext[wrPtr] = FULL;
            wrPtrNext       = PINGPONG ? ~wrPtr : 1'b0;
         end else if (inRange) begin
            bankNext[wrPtr] = FILL;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bankState[0] <= EMPTY;
         bankState[1] <= EMPTY;
         wrPtr        <= 1'b0;
         rdPtr        <= 1'b0;
         err_addr     <= 1'b0;
         err_ovf      <= 1'b0;
         frame_cnt    <= 16'd0;
      end else begin
         bankState[0] <= bankNext[0];
         bankState[1] <= bankNext[1];
         wrPtr        <= wrPtrNext;
         rdPtr        <= rdPtrNext;
         if (wValid && !inRange) begin
            err_addr <= 1'b1;
         end
         if (dropWr) begin
            err_ovf <= 1'b1;
         end
         if (relBank) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   // ---- bank storage: not reset, and never cleared when a bank is reused ----
   always_ff @(posedge clk) begin
      if (acceptWr && inRange) begin
         mem[wrPtr][wAddr] <= in_value;
      end
   end

   // ---- output: the read bank's contents, forced to zero when not valid ----
   always_comb begin
      out_data = '0;
      if (out_valid) begin
         for (int k = 0; k < N; k++) begin
            out_data[k*MAX_BW +: MAX_BW] = mem[rdPtr][k];
         end
      end
   end

endmodule
